// File: rtl/byte_striping.sv
// byte_striping: transmit-side byte striper. Accepts one byte per valid
// cycle and deals consecutive bytes round-robin onto four lanes. Each
// completed or flushed group is presented as one registered 4-lane word
// with a single-cycle valid_out strobe and a mask of the lanes holding
// real data.
module byte_striping #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] PAD    = 8'h00
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              sync_in,
    input  logic              flush_in,
    output logic [DATA_W-1:0] Lane_0,
    output logic [DATA_W-1:0] Lane_1,
    output logic [DATA_W-1:0] Lane_2,
    output logic [DATA_W-1:0] Lane_3,
    output logic              valid_out,
    output logic [3:0]        lane_mask,
    output logic [1:0]        ctr_3
);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] hold      [4];
    logic [DATA_W-1:0] comb_data [4];
    logic [3:0]        fill;
    logic [3:0]        comb_fill;
    logic              full;
    logic              do_emit;

    // The strobe is high exactly in the cycle spent in EMIT.
    assign valid_out = (state == EMIT);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= COLLECT;
        else          state <= state_nxt;
    end

    // Combined group (holding registers plus this cycle's byte) and next state.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        comb_fill = fill;
        for (int i = 0; i < 4; i++) begin
            comb_data[i] = hold[i];
            if (valid_in && ctr_3 == 2'(i)) begin
                comb_data[i] = data_in;
                comb_fill[i] = 1'b1;
            end
        end
        full      = valid_in && (ctr_3 == 2'd3);
        // Sync outranks both a completing byte and a flush request.
        do_emit   = !sync_in && (full || (flush_in && comb_fill != 4'b0000));
        state_nxt = do_emit ? EMIT : COLLECT;
    end

    // Holding stage, lane counter and registered output word.
    // NOTE: the holding registers are a four-entry array, small enough that
    // resetting them costs nothing and keeps a stale partial group invisible.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            fill      <= 4'b0000;
            ctr_3     <= 2'd0;
            Lane_0    <= '0;
            Lane_1    <= '0;
            Lane_2    <= '0;
            Lane_3    <= '0;
            lane_mask <= 4'b0000;
        end else if (sync_in) begin
            // Realign: drop the partial group; a byte arriving now opens lane 0.
            if (valid_in) begin
                hold[0] <= data_in;
                fill    <= 4'b0001;
                ctr_3   <= 2'd1;
            end else begin
                fill    <= 4'b0000;
                ctr_3   <= 2'd0;
            end
        end else if (do_emit) begin
            Lane_0    <= comb_fill[0] ? comb_data[0] : PAD;
            Lane_1    <= comb_fill[1] ? comb_data[1] : PAD;
            Lane_2    <= comb_fill[2] ? comb_data[2] : PAD;
            Lane_3    <= comb_fill[3] ? comb_data[3] : PAD;
            lane_mask <= comb_fill;
            fill      <= 4'b0000;
            ctr_3     <= 2'd0;
        end else if (valid_in) begin
            hold[ctr_3] <= data_in;
            fill        <= comb_fill;
            ctr_3       <= ctr_3 + 2'd1;
        end
    end

endmodule
